pipe_hazard_ctrl: RTL and testbench

Pipelined control unit with integrated hazard handling for the five-stage MIPS-subset datapath. It decodes the ID-stage instruction and carries control words and destination-register addresses through ID/EX, EX/MEM and MEM/WB. It detects load-use and branch/jump hazards and drives the stall, flush and forwarding selects, so the datapath needs no separate hazard or forwarding unit. Its branch resolution, stage carriage and opcode/ALU encodings replace those of the earlier fixed-width control unit.

---
 rtl/pipe_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: decode, stage carriage and hazard/forward control.
// Optional build macro: PIPE_HAZARD_FWD_EN (EX operand forwarding).
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opc,
  input  logic [5:0]        func,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              zero,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              jump,
  output logic              jump_reg,
  output logic              pc_src,
  output logic              ex_alu_src,
  output logic [2:0]        ex_alu_op,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic              wb_write_src,
  output logic [REG_AW-1:0] wb_dst,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  typedef struct packed {
    logic              alu_src;
    logic [2:0]        alu_op;
    logic              branch;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic              write_src;
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } idex_t;

  typedef struct packed {
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic              write_src;
    logic [REG_AW-1:0] dst;
  } exmem_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              write_src;
    logic [REG_AW-1:0] dst;
  } memwb_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [REG_AW-1:0] LINK = REG_AW'(LINK_REG);

  idex_t  idex_q, idex_d, dec;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic rd_rs, rd_rt;
  logic id_jump, id_jr;
  logic [REG_AW-1:0] src_rs, src_rt;
  logic br_taken, hazard, stall;

  function automatic logic hit(
    input logic              we,
    input logic [REG_AW-1:0] dst,
    input logic [REG_AW-1:0] src
  );
    return we && (dst != '0) && (dst == src);
  endfunction

  // ID-stage decode of the opcode/function into a control word
  always_comb begin
    dec     = '0;
    rd_rs   = 1'b0;
    rd_rt   = 1'b0;
    id_jump = 1'b0;
    id_jr   = 1'b0;
    case (opc)
      6'd0: begin
        dec.reg_write = 1'b1;
        dec.dst       = id_rd;
        rd_rs         = 1'b1;
        rd_rt         = 1'b1;
        case (func)
          6'b000001: dec.alu_op = ALU_ADD;
          6'b000010: dec.alu_op = ALU_SUB;
          6'b000100: dec.alu_op = ALU_AND;
          6'b001000: dec.alu_op = ALU_OR;
          6'b010000: dec.alu_op = ALU_SLT;
          default:   dec.alu_op = 3'b000;
        endcase
      end
      6'd1: begin
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.reg_write = 1'b1;
        dec.dst       = id_rt;
        rd_rs         = 1'b1;
      end
      6'd2: begin
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_SLT;
        dec.reg_write = 1'b1;
        dec.dst       = id_rt;
        rd_rs         = 1'b1;
      end
      6'd3: begin
        dec.alu_src    = 1'b1;
        dec.alu_op     = ALU_ADD;
        dec.mem_read   = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.dst        = id_rt;
        rd_rs          = 1'b1;
      end
      6'd4: begin
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.mem_write = 1'b1;
        rd_rs         = 1'b1;
        rd_rt         = 1'b1;
      end
      6'd5: begin
        dec.alu_op = ALU_SUB;
        dec.branch = 1'b1;
        rd_rs      = 1'b1;
        rd_rt      = 1'b1;
      end
      6'd6: id_jump = 1'b1;
      6'd7: begin
        id_jump = 1'b1;
        id_jr   = 1'b1;
        rd_rs   = 1'b1;
      end
      6'd8: begin
        id_jump       = 1'b1;
        dec.reg_write = 1'b1;
        dec.write_src = 1'b1;
        dec.dst       = LINK;
      end
      default: ;
    endcase
    // unread source fields are zeroed so they can never match
    src_rs = rd_rs ? id_rs : '0;
    src_rt = rd_rt ? id_rt : '0;
    dec.rs = src_rs;
    dec.rt = src_rt;
  end

  // hazard detection, priority: taken branch > stall > jump
  always_comb begin
    br_taken = idex_q.branch & zero;
`ifdef PIPE_HAZARD_FWD_EN
    hazard = hit(idex_q.mem_read, idex_q.dst, src_rs)
           | hit(idex_q.mem_read, idex_q.dst, src_rt);
`else
    hazard = hit(idex_q.reg_write, idex_q.dst, src_rs)
           | hit(idex_q.reg_write, idex_q.dst, src_rt)
           | hit(exmem_q.reg_write, exmem_q.dst, src_rs)
           | hit(exmem_q.reg_write, exmem_q.dst, src_rt);
`endif
    stall      = hazard & ~br_taken;
    pc_src     = br_taken;
    jump       = id_jump & ~stall & ~br_taken;
    jump_reg   = id_jr & jump;
    ifid_flush = br_taken | jump;
    pc_write   = ~stall;
    ifid_write = ~stall;
  end

  // EX operand source selection; EX/MEM wins over MEM/WB
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
`ifdef PIPE_HAZARD_FWD_EN
    if (hit(exmem_q.reg_write, exmem_q.dst, idex_q.rs))
      fwd_a = 2'b10;
    else if (hit(memwb_q.reg_write, memwb_q.dst, idex_q.rs))
      fwd_a = 2'b01;
    if (hit(exmem_q.reg_write, exmem_q.dst, idex_q.rt))
      fwd_b = 2'b10;
    else if (hit(memwb_q.reg_write, memwb_q.dst, idex_q.rt))
      fwd_b = 2'b01;
`endif
  end

`ifndef PIPE_HAZARD_FWD_EN
  logic unused_src;
  assign unused_src = ^{idex_q.rs, idex_q.rt};
`endif

  // next-state of the stage registers; stall or taken branch inject a bubble
  always_comb begin
    idex_d = (stall | br_taken) ? '0 : dec;
    exmem_d = '{
      mem_read:   idex_q.mem_read,
      mem_write:  idex_q.mem_write,
      reg_write:  idex_q.reg_write,
      mem_to_reg: idex_q.mem_to_reg,
      write_src:  idex_q.write_src,
      dst:        idex_q.dst
    };
    memwb_d = '{
      reg_write:  exmem_q.reg_write,
      mem_to_reg: exmem_q.mem_to_reg,
      write_src:  exmem_q.write_src,
      dst:        exmem_q.dst
    };
  end

  // stage registers, cleared to bubbles on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ex_alu_src    = idex_q.alu_src;
  assign ex_alu_op     = idex_q.alu_op;
  assign mem_read      = exmem_q.mem_read;
  assign mem_write     = exmem_q.mem_write;
  assign wb_reg_write  = memwb_q.reg_write;
  assign wb_mem_to_reg = memwb_q.mem_to_reg;
  assign wb_write_src  = memwb_q.write_src;
  assign wb_dst        = memwb_q.dst;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors for pipe_hazard_ctrl.
// Expectations adapt to PIPE_HAZARD_FWD_EN.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opc, func;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       zero;
  logic       pc_write, ifid_write, ifid_flush;
  logic       jump, jump_reg, pc_src;
  logic       ex_alu_src;
  logic [2:0] ex_alu_op;
  logic       mem_read, mem_write;
  logic       wb_reg_write, wb_mem_to_reg, wb_write_src;
  logic [4:0] wb_dst;
  logic [1:0] fwd_a, fwd_b;

  int total = 0;
  int bad   = 0;

`ifdef PIPE_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  pipe_hazard_ctrl #(.REG_AW(5), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst),
    .opc(opc), .func(func),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .zero(zero),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush),
    .jump(jump), .jump_reg(jump_reg), .pc_src(pc_src),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .mem_read(mem_read), .mem_write(mem_write),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_write_src(wb_write_src), .wb_dst(wb_dst),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic [5:0] o, input logic [5:0] f,
                    input logic [4:0] s, input logic [4:0] t,
                    input logic [4:0] d);
    opc = o; func = f; id_rs = s; id_rt = t; id_rd = d;
    #1;
  endtask

  task automatic idle();
    id(6'd63, 6'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; zero = 1'b0;
    idle();
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_pcw", pc_write, 1);
    chk("rst_ifw", ifid_write, 1);
    chk("rst_flush", ifid_flush, 0);
    chk("rst_jump", jump, 0);
    chk("rst_pcsrc", pc_src, 0);
    chk("rst_aluop", ex_alu_op, 0);
    chk("rst_memrd", mem_read, 0);
    chk("rst_wbwe", wb_reg_write, 0);
    chk("rst_wbdst", wb_dst, 0);
    chk("rst_fwd", {fwd_a, fwd_b}, 0);

    // add $3,$1,$2 ; sub $4,$3,$1
    id(6'd0, 6'b000001, 5'd1, 5'd2, 5'd3);
    chk("add_pcw", pc_write, 1);
    tick();
    id(6'd0, 6'b000010, 5'd3, 5'd1, 5'd4);
    chk("add_exop", ex_alu_op, 3'b010);
    chk("sub_pcw", pc_write, FWD);
    tick();
    if (FWD) begin
      idle();
      chk("sub_fwda", fwd_a, 2'b10);
      chk("sub_fwdb", fwd_b, 2'b00);
      chk("sub_exop", ex_alu_op, 3'b110);
      tick();
      chk("add_wbdst", wb_dst, 3);
      chk("add_wbwe", wb_reg_write, 1);
    end else begin
      chk("sub_pcw2", pc_write, 0);
      chk("sub_bub", ex_alu_op, 0);
      tick();
      chk("add_wbdst", wb_dst, 3);
      chk("add_wbwe", wb_reg_write, 1);
      chk("sub_pcw3", pc_write, 1);
      tick();
      idle();
      chk("sub_exop", ex_alu_op, 3'b110);
      chk("sub_fwda", fwd_a, 2'b00);
    end
    drain();

    // lw $5,0($1) ; add $6,$5,$5
    id(6'd3, 6'd0, 5'd1, 5'd5, 5'd0);
    tick();
    id(6'd0, 6'b000001, 5'd5, 5'd5, 5'd6);
    chk("lu_pcw", pc_write, 0);
    chk("lu_ifw", ifid_write, 0);
    tick();
    chk("lu_bub", ex_alu_op, 0);
    chk("lu_memrd", mem_read, 1);
    chk("lu_pcw2", pc_write, FWD);
    tick();
    chk("lu_wbm2r", wb_mem_to_reg, 1);
    if (FWD) begin
      idle();
      chk("lu_fwd", {fwd_a, fwd_b}, 4'b0101);
      chk("lu_exop", ex_alu_op, 3'b010);
    end else begin
      chk("lu_pcw3", pc_write, 1);
      tick();
      idle();
      chk("lu_fwd", {fwd_a, fwd_b}, 4'b0000);
      chk("lu_exop", ex_alu_op, 3'b010);
    end
    drain();

    // beq taken, addi behind it is squashed
    id(6'd5, 6'd0, 5'd1, 5'd2, 5'd0);
    tick();
    id(6'd1, 6'd0, 5'd0, 5'd7, 5'd0);
    zero = 1'b1; #1;
    chk("bt_exop", ex_alu_op, 3'b110);
    chk("bt_pcsrc", pc_src, 1);
    chk("bt_flush", ifid_flush, 1);
    chk("bt_pcw", pc_write, 1);
    tick();
    zero = 1'b0;
    chk("bt_bub", {ex_alu_src, ex_alu_op}, 0);
    drain();

    // beq not taken
    id(6'd5, 6'd0, 5'd1, 5'd2, 5'd0);
    tick();
    id(6'd1, 6'd0, 5'd0, 5'd7, 5'd0);
    chk("bn_pcsrc", pc_src, 0);
    chk("bn_flush", ifid_flush, 0);
    tick();
    chk("bn_addi", {ex_alu_src, ex_alu_op}, 4'b1010);
    drain();

    // jal behind taken beq
    id(6'd5, 6'd0, 5'd1, 5'd2, 5'd0);
    tick();
    id(6'd8, 6'd0, 5'd0, 5'd0, 5'd0);
    zero = 1'b1; #1;
    chk("bj_jump", jump, 0);
    chk("bj_pcsrc", pc_src, 1);
    chk("bj_flush", ifid_flush, 1);
    tick();
    zero = 1'b0;
    drain();
    chk("bj_nowb", wb_reg_write, 0);

    // standalone jal
    id(6'd8, 6'd0, 5'd0, 5'd0, 5'd0);
    chk("jal_jump", {jump, jump_reg, ifid_flush}, 3'b101);
    tick();
    idle();
    tick(); tick();
    chk("jal_wbdst", wb_dst, 31);
    chk("jal_wsrc", wb_write_src, 1);
    chk("jal_wbwe", wb_reg_write, 1);
    drain();

    // jr $5 behind lw $5 is held
    id(6'd3, 6'd0, 5'd1, 5'd5, 5'd0);
    tick();
    id(6'd7, 6'd0, 5'd5, 5'd0, 5'd0);
    chk("jrs_jump", jump, 0);
    chk("jrs_pcw", pc_write, 0);
    tick();
    chk("jrs_jump2", {jump, jump_reg}, FWD ? 2'b11 : 2'b00);
    drain();

    // reset during a load-use stall
    id(6'd3, 6'd0, 5'd1, 5'd5, 5'd0);
    tick();
    id(6'd0, 6'b000001, 5'd5, 5'd0, 5'd6);
    chk("rs_pcw", pc_write, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("rs_pcw2", pc_write, 1);
    chk("rs_memrd", mem_read, 0);
    chk("rs_exop", ex_alu_op, 0);
    tick();
    chk("rs_wb", {wb_reg_write, wb_mem_to_reg}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
